// File: rtl/gestor_necesidades_pkg.sv
// -----------------------------------------------------------------------------
// gestor_necesidades_pkg
// Shared definitions for the pet-needs blocks: level width and ceiling,
// pet state encodings, and small helpers for saturating level arithmetic and
// state classification. The display block imports the same constants so both
// sides agree on the level range and the state codes.
// -----------------------------------------------------------------------------
package gestor_necesidades_pkg;

  // Level registers are 3 bits wide; MAX_LEVEL must fit in them.
  localparam int NIVEL_W   = 3;
  localparam int MAX_LEVEL = 5;
  localparam int ESTADO_W  = 3;

  typedef logic [NIVEL_W-1:0]  nivel_t;
  typedef logic [ESTADO_W-1:0] estado_t;

  // Pet state encodings shown by the display and read by the mode FSM.
  localparam estado_t NORMAL     = 3'd0;
  localparam estado_t HAMBRIENTO = 3'd1;
  localparam estado_t ENFERMO    = 3'd2;
  localparam estado_t CRITICO    = 3'd3;
  localparam estado_t MUERTO     = 3'd4;

  // Increment that sticks at the ceiling.
  function automatic nivel_t sumar_sat(input nivel_t valor, input nivel_t tope);
    if (valor >= tope) begin
      return tope;
    end
    return valor + nivel_t'(1);
  endfunction

  // Decrement that sticks at zero.
  function automatic nivel_t restar_sat(input nivel_t valor);
    if (valor == '0) begin
      return '0;
    end
    return valor - nivel_t'(1);
  endfunction

  // Maps the two levels onto a pet state. Death takes priority over every
  // other condition; "low" means at or below the threshold.
  function automatic estado_t clasificar_estado(input nivel_t comida,
                                                input nivel_t salud,
                                                input nivel_t umbral);
    logic comida_baja;
    logic salud_baja;
    comida_baja = (comida <= umbral);
    salud_baja  = (salud <= umbral);
    if (salud == '0) begin
      return MUERTO;
    end
    if (comida_baja && salud_baja) begin
      return CRITICO;
    end
    if (salud_baja) begin
      return ENFERMO;
    end
    if (comida_baja) begin
      return HAMBRIENTO;
    end
    return NORMAL;
  endfunction

endpackage

// File: rtl/gestor_necesidades_base_segundos.sv
// -----------------------------------------------------------------------------
// base_segundos
// Seconds time base. Counts clk cycles 0..CYCLES_PER_SEC-1 and raises tick for
// the single cycle the count sits on its terminal value, then wraps to 0.
//   modo_test = 1 : prescaler held at 0, tick asserted every cycle.
//   pausa     = 1 : prescaler holds its value and tick stays low
//                   (pausa takes priority over modo_test).
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-low reset (count returns to 0)
//   modo_test - bypass the prescaler
//   pausa     - freeze the time base
//   tick      - one-cycle seconds strobe
// -----------------------------------------------------------------------------
module base_segundos #(
  parameter int CYCLES_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic modo_test,
  input  logic pausa,
  output logic tick
);

  // A one-cycle period still needs a 1-bit register to keep the code regular.
  localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PW-1:0] TERMINAL = PW'(CYCLES_PER_SEC - 1);

  logic [PW-1:0] cuenta;
  logic          terminal;

  assign terminal = (cuenta == TERMINAL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cuenta <= '0;
    end else if (pausa) begin
      cuenta <= cuenta;
    end else if (modo_test || terminal) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta + PW'(1);
    end
  end

  // Combinational strobe: it is valid in the same cycle the count reaches the
  // terminal value, so consumers act on it at the wrapping edge.
  assign tick = !pausa && (modo_test || terminal);

endmodule

// File: rtl/gestor_necesidades.sv
// -----------------------------------------------------------------------------
// gestor_necesidades
// Keeps the pet's food (comida) and health (salud) levels. Both decay on a
// seconds time base, are raised by one-cycle action pulses from the button
// blocks, and are summarised into a registered pet state for the display and
// the mode FSM.
//
// Pulse handshake: senal_comida / senal_salud carry no ready. Every cycle a
// pulse input is high counts as one action and is consumed at that edge;
// upstream guarantees single-cycle pulses.
//
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-low reset
//   senal_comida - feed pulse (+1 food, restarts the food decay interval)
//   senal_salud  - heal pulse (+1 health, only while food is not empty)
//   modo_test    - tick every clk instead of once per second
//   pausa        - freeze decay; pulses are still accepted
//   nivel_comida - food level 0..MAX_LEVEL
//   nivel_salud  - health level 0..MAX_LEVEL
//   estado       - pet state (registered, lags the levels by one clk)
//   alarma       - high while estado is CRITICO or MUERTO
// -----------------------------------------------------------------------------
module gestor_necesidades #(
  parameter int CYCLES_PER_SEC = 50_000_000,
  parameter int MAX_LEVEL      = gestor_necesidades_pkg::MAX_LEVEL,
  parameter int DECAY_COMIDA_S = 10,
  parameter int DECAY_SALUD_S  = 20,
  parameter int UMBRAL_BAJO    = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    senal_comida,
  input  logic                                    senal_salud,
  input  logic                                    modo_test,
  input  logic                                    pausa,
  output logic [gestor_necesidades_pkg::NIVEL_W-1:0]  nivel_comida,
  output logic [gestor_necesidades_pkg::NIVEL_W-1:0]  nivel_salud,
  output logic [gestor_necesidades_pkg::ESTADO_W-1:0] estado,
  output logic                                    alarma
);

  import gestor_necesidades_pkg::*;

  // Decay counters run 0..limit-1, so they only need to hold the longest
  // interval minus one.
  localparam int CW_C = (DECAY_COMIDA_S > 1) ? $clog2(DECAY_COMIDA_S) : 1;
  localparam int CW_S = (DECAY_SALUD_S > 1) ? $clog2(DECAY_SALUD_S) : 1;

  localparam nivel_t            MAX_L      = nivel_t'(MAX_LEVEL);
  localparam nivel_t            UMBRAL_L   = nivel_t'(UMBRAL_BAJO);
  localparam logic [CW_C-1:0]   ULT_C      = CW_C'(DECAY_COMIDA_S - 1);
  localparam logic [CW_S-1:0]   ULT_S_NORM = CW_S'(DECAY_SALUD_S - 1);
  localparam logic [CW_S-1:0]   ULT_S_HAMB = CW_S'((DECAY_SALUD_S / 2) - 1);

  logic            tick;
  logic [CW_C-1:0] cnt_c;
  logic [CW_S-1:0] cnt_s;

  logic            vivo;
  logic [CW_S-1:0] ult_s;
  nivel_t          comida_sig;
  nivel_t          salud_sig;
  logic [CW_C-1:0] cnt_c_sig;
  logic [CW_S-1:0] cnt_s_sig;
  estado_t         estado_sig;
  logic            alarma_sig;

  base_segundos #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_base_segundos (
    .clk      (clk),
    .reset    (reset),
    .modo_test(modo_test),
    .pausa    (pausa),
    .tick     (tick)
  );

  // Health reaching zero is terminal: nothing moves again until reset. Since
  // only a heal could lift salud off zero, gating on the level itself keeps
  // MUERTO sticky without waiting for the registered state.
  assign vivo = (nivel_salud != '0);

  // Starvation halves the health interval. Comparing with >= means a counter
  // already past the shortened limit fires on the very next tick.
  assign ult_s = (nivel_comida == '0) ? ULT_S_HAMB : ULT_S_NORM;

  always_comb begin
    comida_sig = nivel_comida;
    salud_sig  = nivel_salud;
    cnt_c_sig  = cnt_c;
    cnt_s_sig  = cnt_s;

    if (vivo) begin
      // Food: a feed pulse restarts the interval and overrides any decay due
      // in the same cycle.
      if (senal_comida) begin
        comida_sig = sumar_sat(nivel_comida, MAX_L);
        cnt_c_sig  = '0;
      end else if (tick) begin
        if (cnt_c >= ULT_C) begin
          comida_sig = restar_sat(nivel_comida);
          cnt_c_sig  = '0;
        end else begin
          cnt_c_sig = cnt_c + CW_C'(1);
        end
      end

      // Health: a heal is only honoured when the pre-update food level is
      // non-zero; a refused heal leaves the decay path running untouched.
      if (senal_salud && (nivel_comida != '0)) begin
        salud_sig = sumar_sat(nivel_salud, MAX_L);
        cnt_s_sig = '0;
      end else if (tick) begin
        if (cnt_s >= ult_s) begin
          salud_sig = restar_sat(nivel_salud);
          cnt_s_sig = '0;
        end else begin
          cnt_s_sig = cnt_s + CW_S'(1);
        end
      end
    end

    // State follows the levels currently held, hence the one-clk lag.
    estado_sig = clasificar_estado(nivel_comida, nivel_salud, UMBRAL_L);
    alarma_sig = (estado_sig == CRITICO) || (estado_sig == MUERTO);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      nivel_comida <= MAX_L;
      nivel_salud  <= MAX_L;
      cnt_c        <= '0;
      cnt_s        <= '0;
      estado       <= NORMAL;
      alarma       <= 1'b0;
    end else begin
      nivel_comida <= comida_sig;
      nivel_salud  <= salud_sig;
      cnt_c        <= cnt_c_sig;
      cnt_s        <= cnt_s_sig;
      estado       <= estado_sig;
      alarma       <= alarma_sig;
    end
  end

endmodule

// File: tb/tb_gestor_necesidades.sv
// -----------------------------------------------------------------------------
// tb_gestor_necesidades
// Directed scenarios followed by randomized pulses/pause/reset, checked every
// cycle against a behavioural model of the pet's needs, plus literal
// expectations at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_gestor_necesidades;

  localparam int CPS  = 4;
  localparam int MAXL = 5;
  localparam int DC   = 10;
  localparam int DS   = 20;
  localparam int UMB  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       senal_comida;
  logic       senal_salud;
  logic       modo_test;
  logic       pausa;
  logic [2:0] nivel_comida;
  logic [2:0] nivel_salud;
  logic [2:0] estado;
  logic       alarma;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  int m_food, m_health, m_cc, m_cs, m_pre, m_est;
  bit m_alm;

  gestor_necesidades #(
    .CYCLES_PER_SEC(CPS),
    .MAX_LEVEL     (MAXL),
    .DECAY_COMIDA_S(DC),
    .DECAY_SALUD_S (DS),
    .UMBRAL_BAJO   (UMB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .senal_comida(senal_comida),
    .senal_salud (senal_salud),
    .modo_test   (modo_test),
    .pausa       (pausa),
    .nivel_comida(nivel_comida),
    .nivel_salud (nivel_salud),
    .estado      (estado),
    .alarma      (alarma)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int classify(input int c, input int s);
    if (s == 0) return 4;
    if (c <= UMB && s <= UMB) return 3;
    if (s <= UMB) return 2;
    if (c <= UMB) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin : modelo
    bit tk;
    int nf, nh, lim;
    if (!reset) begin
      m_food = MAXL; m_health = MAXL; m_cc = 0; m_cs = 0; m_pre = 0;
      m_est = 0; m_alm = 1'b0;
    end else begin
      tk = !pausa && (modo_test || m_pre == CPS - 1);
      if (!pausa) m_pre = (modo_test || m_pre == CPS - 1) ? 0 : m_pre + 1;
      nf = m_food;
      nh = m_health;
      if (m_health > 0) begin
        if (senal_comida) begin
          nf = (m_food < MAXL) ? m_food + 1 : MAXL;
          m_cc = 0;
        end else if (tk) begin
          m_cc++;
          if (m_cc >= DC) begin
            nf = (m_food > 0) ? m_food - 1 : 0;
            m_cc = 0;
          end
        end
        lim = (m_food == 0) ? DS / 2 : DS;
        if (senal_salud && m_food != 0) begin
          nh = (m_health < MAXL) ? m_health + 1 : MAXL;
          m_cs = 0;
        end else if (tk) begin
          m_cs++;
          if (m_cs >= lim) begin
            nh = (m_health > 0) ? m_health - 1 : 0;
            m_cs = 0;
          end
        end
      end
      m_est = classify(m_food, m_health);
      m_alm = (m_est == 3) || (m_est == 4);
      m_food = nf;
      m_health = nh;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("nivel_comida", int'(nivel_comida), m_food);
      check("nivel_salud", int'(nivel_salud), m_health);
      check("estado", int'(estado), m_est);
      check("alarma", int'(alarma), int'(m_alm));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input bit c, input bit s);
    senal_comida = c;
    senal_salud  = s;
    step(1);
    senal_comida = 1'b0;
    senal_salud  = 1'b0;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic pin(input string name, input int dut_v, input int mdl_v, input int lit);
    check({name, "_dut"}, dut_v, lit);
    check({name, "_model"}, mdl_v, lit);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; senal_comida = 1'b0; senal_salud = 1'b0;
    modo_test = 1'b1; pausa = 1'b0;
    step(3);
    chk_en = 1'b1;
    pin("rst_comida", int'(nivel_comida), m_food, 5);
    pin("rst_salud", int'(nivel_salud), m_health, 5);
    pin("rst_estado", int'(estado), m_est, 0);
    pin("rst_alarma", int'(alarma), int'(m_alm), 0);

    // Reset and decay in test mode (edge numbers counted from release).
    reset = 1'b1;
    step(10);                                                // edge 10
    pin("decay10_comida", int'(nivel_comida), m_food, 4);
    step(10);                                                // edge 20
    pin("decay20_comida", int'(nivel_comida), m_food, 3);
    pin("decay20_salud", int'(nivel_salud), m_health, 4);

    // Feed on the cycle a decay is due: feed wins, interval restarts.
    step(9);                                                 // edge 29
    pulse(1'b1, 1'b0);                                       // edge 30
    pin("feed_wins", int'(nivel_comida), m_food, 4);
    step(9);                                                 // edge 39
    pin("feed_restart_hold", int'(nivel_comida), m_food, 4);
    step(1);                                                 // edge 40
    pin("feed_restart_dec", int'(nivel_comida), m_food, 3);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);                                       // edge 43
    pin("feed_saturate", int'(nivel_comida), m_food, 5);

    // Heal back up, then starve.
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);                                       // edge 45
    pin("heal_up", int'(nivel_salud), m_health, 5);
    step(48);                                                // edge 93
    pin("starve_comida", int'(nivel_comida), m_food, 0);
    pin("starve_salud", int'(nivel_salud), m_health, 3);
    step(2);                                                 // edge 95
    pin("halved_interval", int'(nivel_salud), m_health, 2);
    pin("estado_lag", int'(estado), m_est, 1);
    pin("alarma_lag", int'(alarma), int'(m_alm), 0);
    step(1);                                                 // edge 96
    pin("critico", int'(estado), m_est, 3);
    pin("critico_alarma", int'(alarma), int'(m_alm), 1);
    pulse(1'b0, 1'b1);                                       // edge 97
    pin("heal_ignored", int'(nivel_salud), m_health, 2);
    pulse(1'b1, 1'b1);                                       // edge 98
    pin("both_comida", int'(nivel_comida), m_food, 1);
    pin("both_salud", int'(nivel_salud), m_health, 2);

    // Death and freeze.
    step(25);                                                // edge 123
    pin("dead_salud", int'(nivel_salud), m_health, 0);
    pin("dead_estado", int'(estado), m_est, 4);
    pin("dead_alarma", int'(alarma), int'(m_alm), 1);
    pulse(1'b1, 1'b1);
    step(20);
    pin("frozen_comida", int'(nivel_comida), m_food, 0);
    pin("frozen_salud", int'(nivel_salud), m_health, 0);
    pin("frozen_estado", int'(estado), m_est, 4);

    // Reset out of MUERTO, prescaler running (tick every 4th clk).
    reset = 1'b0;
    modo_test = 1'b0;
    step(1);
    pin("rst2_comida", int'(nivel_comida), m_food, 5);
    pin("rst2_estado", int'(estado), m_est, 0);
    pin("rst2_alarma", int'(alarma), int'(m_alm), 0);
    reset = 1'b1;
    step(39);
    pin("presc39", int'(nivel_comida), m_food, 5);
    step(1);
    pin("presc40", int'(nivel_comida), m_food, 4);

    // Pause freezes decay; release resumes from the held counts.
    pausa = 1'b1;
    step(100);
    pin("pause_comida", int'(nivel_comida), m_food, 4);
    pin("pause_salud", int'(nivel_salud), m_health, 5);
    pausa = 1'b0;
    step(39);
    pin("resume_hold", int'(nivel_comida), m_food, 4);
    step(1);
    pin("resume_comida", int'(nivel_comida), m_food, 3);
    pin("resume_salud", int'(nivel_salud), m_health, 4);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 249) != 0);
      modo_test    = ($urandom_range(0, 7) != 0);
      pausa        = ($urandom_range(0, 9) == 0);
      senal_comida = ($urandom_range(0, 11) == 0);
      senal_salud  = ($urandom_range(0, 7) == 0);
      step(1);
    end
    senal_comida = 1'b0;
    senal_salud  = 1'b0;
    step(2);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gestor_necesidades.md
Name: gestor_necesidades

Overview:
- Downstream consumer of the one-cycle action pulses produced by the food/health button blocks.
- Holds the pet's food (comida) and health (salud) levels and decays them on a seconds time base.
- Raises a level when an action pulse arrives.
- Derives a registered pet state (NORMAL/HAMBRIENTO/ENFERMO/CRITICO/MUERTO) for the display and mode FSM.

Parameters:
- CYCLES_PER_SEC, 50_000_000: clk cycles per 1 s tick.
- MAX_LEVEL, 5: saturation value of both levels; must fit in 3 bits.
- DECAY_COMIDA_S, 10: seconds between food decrements.
- DECAY_SALUD_S, 20: seconds between health decrements; halved (integer division) while comida==0.
- UMBRAL_BAJO, 2: a level <= this value counts as "low".

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-low reset.
- senal_comida, input, 1: one-cycle feed pulse from the food button block.
- senal_salud, input, 1: one-cycle heal pulse from the health button block.
- modo_test, input, 1: 1 = seconds prescaler bypassed, tick every clk.
- pausa, input, 1: 1 = decay frozen; pulses still accepted.
- nivel_comida, output, 3: food level 0..MAX_LEVEL.
- nivel_salud, output, 3: health level 0..MAX_LEVEL.
- estado, output, 3: pet state encoding.
- alarma, output, 1: high in CRITICO or MUERTO.

Behaviour:
- Reset (reset==0 at posedge): nivel_comida=nivel_salud=MAX_LEVEL, estado=NORMAL(0), alarma=0, prescaler and both decay counters = 0.
- Prescaler: counts 0..CYCLES_PER_SEC-1; tick = 1 for one cycle on the terminal count, then wraps to 0.
  - modo_test=1: tick=1 every cycle, prescaler held at 0.
  - pausa=1: prescaler and decay counters hold; no tick.
- Food decay counter, per tick:
  - If cnt_c == DECAY_COMIDA_S-1: nivel_comida -= 1 (floor 0) and cnt_c <= 0.
  - Otherwise cnt_c += 1.
- Health decay counter: same rule with limit L_s.
  - L_s = DECAY_SALUD_S normally; L_s = DECAY_SALUD_S/2 while nivel_comida==0.
  - If cnt_s >= L_s-1 when L_s shrinks, decrement on the next tick.
- Feed pulse (senal_comida=1):
  - nivel_comida += 1, saturating at MAX_LEVEL; cnt_c <= 0.
  - The pulse wins over a same-cycle decay: no decrement that cycle.
- Heal pulse (senal_salud=1):
  - nivel_salud += 1 (saturating) and cnt_s <= 0, only if nivel_comida != 0.
  - Ignored while nivel_comida==0; cnt_s is untouched in that case.
- Both pulses in the same cycle: both applied independently. Heal is gated by the pre-update nivel_comida.
- Level updates are visible at the edge where they occur; latency 1 clk from pulse to level.
- estado is registered from the current levels, so it lags the levels by 1 clk:
  - MUERTO(4): nivel_salud==0. Sticky: levels freeze, pulses and decay ignored, alarma=1 until reset.
  - CRITICO(3): both levels <= UMBRAL_BAJO.
  - ENFERMO(2): salud <= UMBRAL_BAJO, comida > UMBRAL_BAJO.
  - HAMBRIENTO(1): comida <= UMBRAL_BAJO, salud > UMBRAL_BAJO.
  - NORMAL(0): otherwise.
- alarma is registered alongside estado and is never high in the same cycle estado changes out of CRITICO.
- Reset mid-operation: all counters and levels return to their reset values on that edge, including from MUERTO.
- Pulses longer than 1 cycle count once per cycle high. Upstream guarantees one-cycle pulses.

Decomposition:
- Shared package holds:
  - estado encodings NORMAL, HAMBRIENTO, ENFERMO, CRITICO, MUERTO (3-bit localparams).
  - MAX_LEVEL and level width (3), shared with the display block.
- Sub-module base_segundos: the prescaler with modo_test/pausa; outputs tick. Reused by other timed blocks.
- Decay counters, level registers and state logic stay in gestor_necesidades.

Test Plan:
- Reset and decay: release reset, modo_test=1, defaults -> comida=5, salud=5, estado=0, alarma=0 at release; comida=4 after 10 clks, comida=3 after 20 clks; salud=4 after 20 clks.
- Feed vs decay: pulse senal_comida on the same cycle comida would decay 4->3 -> comida=5, no decrement, next decrement 10 ticks later; feeding at 5 stays 5.
- Starvation: drive comida to 0 without feeding -> health interval becomes 10 ticks; senal_salud ignored (salud unchanged); estado reaches CRITICO(3) with alarma=1 one clk after both levels <= 2.
- Death: let salud reach 0 -> estado=MUERTO(4) next clk, alarma=1; later pulses and ticks leave both levels frozen; reset low one edge -> levels 5, estado 0, alarma 0.
- Pause and prescaler: modo_test=0, CYCLES_PER_SEC=4 -> tick every 4th clk, food decrements 40 clks after release; pausa=1 for 100 clks -> no change; release resumes from the held counter values.
- Simultaneous pulses: senal_comida=senal_salud=1 with comida=0, salud=3 -> comida=1, salud=3 (heal gated on pre-update comida).
